kpn_fifo_channel: RTL and testbench
===================================

Name: kpn_fifo_channel

Overview:
- Bounded FIFO channel that sits between two KPN process modules (adder, multiplier, splitter, etc.).
- Producer side: its `wr` output drives this block's `wr`, and its result drives `entry_1`.
- Consumer side: its `rd` output drives this block's `rd`, and it reads `output_1`.
- Implements KPN blocking semantics: writes are refused when full, reads are refused when empty. Status flags let the processes stall.

Parameters:
- DATA_WIDTH, 16, token width in bits.
- DEPTH, 8, number of token slots; power of two, minimum 2.
- ADDR_WIDTH, 3, log2(DEPTH); must match DEPTH.
- INIT_VALUE, 16'd0, value of the preloaded token (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr  input  1  producer write request, sampled at posedge clk.
- entry_1  input  DATA_WIDTH  producer token, sampled with wr.
- rd  input  1  consumer read request, sampled at posedge clk.
- output_1  output  DATA_WIDTH  registered token delivered to the consumer.
- out_valid  output  1  high for exactly one cycle when output_1 carries a newly popped token.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- count  output  ADDR_WIDTH+1  number of stored tokens, 0..DEPTH.
- overflow  output  1  one-cycle pulse when a write was refused.
- underflow  output  1  one-cycle pulse when a read was refused.

Behaviour:
- Reset: rst_n low forces, asynchronously:
  - write pointer and read pointer = 0, count = 0;
  - empty = 1, full = 0;
  - output_1 = 0, out_valid = 0, overflow = 0, underflow = 0.
  - Memory contents are don't-care.
- Reset mid-operation: all stored tokens are discarded. The first cycle after rst_n rises behaves as a fresh, empty channel.
- Write acceptance: wr_ok = wr & ~full.
  - On wr_ok: mem[wptr] <= entry_1, and wptr advances by 1, wrapping DEPTH-1 -> 0.
- Read acceptance: rd_ok = rd & ~empty.
  - On rd_ok: output_1 <= mem[rptr], out_valid <= 1, and rptr advances by 1 with the same wrap.
  - Read latency is one clock: the token is visible on output_1 with out_valid high in the cycle after rd is sampled.
- out_valid is 0 in every cycle that does not follow an accepted read.
- output_1 holds its last value until the next accepted read.
- Count update: count_next = count + wr_ok - rd_ok, evaluated in one expression.
  - Simultaneous rd_ok and wr_ok leaves count unchanged; both pointers advance.
- Full, with wr and rd both asserted: the read is accepted and the write is refused (overflow pulses).
  - There is no write-through-on-full; the producer retries next cycle.
- Empty, with wr and rd both asserted: the write is accepted and the read is refused (underflow pulses).
  - There is no bypass; the token becomes readable the following cycle.
- overflow <= wr & full; underflow <= rd & empty. Each is registered and lasts one cycle per refused attempt.
- full, empty and count are derived from registered count, so they update in the cycle after the causing edge.
- Data ordering is strictly FIFO. No token is ever duplicated or lost, except through a refused write, which the producer must retry.
- A continuous rd/wr stream at one token per cycle sustains full throughput when 0 < count < DEPTH.

Optional Feature:
- Macro: KPN_CHANNEL_INIT_TOKEN_EN.
- Defined: reset preloads one token, for KPN feedback loops that need an initial delay token.
  - mem[0] = INIT_VALUE, wptr = 1, rptr = 0, count = 1.
  - empty = 0, full = 0 (DEPTH >= 2).
  - The first accepted read returns INIT_VALUE.
- Not defined: reset leaves the channel empty as described above; INIT_VALUE is unused.

Test Plan:
1. Reset with DEPTH=8: hold rst_n=0 for 3 cycles with wr=1 and rd=1 toggling.
   -> count=0, empty=1, full=0, output_1=0, out_valid=0 throughout; no pointer movement.
2. Write 16'h0003, 16'h0005, 16'h0007 on consecutive cycles, then rd for 3 cycles.
   -> output_1 = 3, 5, 7 on cycles rd+1, rd+2, rd+3, each with out_valid=1; count returns to 0 and empty=1.
3. Write 9 tokens 1..9 back-to-back (DEPTH=8).
   -> full=1 after the 8th; the 9th is refused and overflow pulses once.
   -> Draining 8 reads yields 1..8; token 9 is absent.
4. At full, assert wr=1 (data 16'h00AA) and rd=1 in the same cycle.
   -> Oldest token is popped, the write is refused, overflow=1, count=7.
   -> The next cycle, wr of 16'h00AA is accepted and count=8.
5. At empty, assert wr=1 (data 16'h1234) and rd=1 in the same cycle.
   -> underflow=1, count=1, no out_valid.
   -> Next cycle rd -> output_1=16'h1234 with out_valid=1.
6. Wrap and reset: write/read 20 tokens continuously at 1 token/cycle, then pull rst_n low mid-stream with count=4.
   -> Ordering is preserved across pointer wrap; after reset count=0.
   -> With KPN_CHANNEL_INIT_TOKEN_EN and INIT_VALUE=16'h0010, count=1 after reset and the first read returns 16'h0010.

Source files
------------

// File: rtl/kpn_fifo_channel_if.sv
// kpn_fifo_channel_if: producer/consumer handshake bundle of a KPN FIFO channel.
`timescale 1ns/1ps
interface kpn_fifo_channel_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  wr;
    logic [DATA_WIDTH-1:0] entry_1;
    logic                  rd;
    logic [DATA_WIDTH-1:0] output_1;
    logic                  out_valid;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr, entry_1, rd,
        input  output_1, out_valid, full, empty, count, overflow, underflow
    );
    modport slave (
        input  wr, entry_1, rd,
        output output_1, out_valid, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/kpn_fifo_channel.sv
// kpn_fifo_channel: bounded blocking FIFO between two KPN processes.
// Define KPN_CHANNEL_INIT_TOKEN_EN to preload one INIT_VALUE token at reset.
`timescale 1ns/1ps
module kpn_fifo_channel #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    DEPTH      = 8,
    parameter int                    ADDR_WIDTH = 3,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    kpn_fifo_channel_if.slave  ch
);
    localparam int CW = ADDR_WIDTH + 1;
`ifdef KPN_CHANNEL_INIT_TOKEN_EN
    localparam logic [ADDR_WIDTH-1:0] WPTR_RST  = ADDR_WIDTH'(1);
    localparam logic [CW-1:0]         COUNT_RST = CW'(1);
`else
    localparam logic [ADDR_WIDTH-1:0] WPTR_RST  = '0;
    localparam logic [CW-1:0]         COUNT_RST = '0;
`endif

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] output_1_q, output_1_d;
    logic                  out_valid_q, overflow_q, underflow_q;
    logic                  full, empty, wr_ok, rd_ok;

    always_comb begin
        full       = count_q == CW'(DEPTH);
        empty      = count_q == '0;
        wr_ok      = ch.wr & ~full;
        rd_ok      = ch.rd & ~empty;
        wptr_d     = wptr_q + ADDR_WIDTH'(wr_ok);
        rptr_d     = rptr_q + ADDR_WIDTH'(rd_ok);
        count_d    = count_q + CW'(wr_ok) - CW'(rd_ok);
        output_1_d = rd_ok ? mem_q[rptr_q] : output_1_q;
    end

    // Slot 0 always resets to INIT_VALUE; it is only observable when preloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_q[0] <= INIT_VALUE;
        else if (wr_ok) mem_q[wptr_q] <= ch.entry_1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= WPTR_RST;
            rptr_q      <= '0;
            count_q     <= COUNT_RST;
            output_1_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            output_1_q  <= output_1_d;
            out_valid_q <= rd_ok;
            overflow_q  <= ch.wr & full;
            underflow_q <= ch.rd & empty;
        end
    end

    assign ch.output_1  = output_1_q;
    assign ch.out_valid = out_valid_q;
    assign ch.full      = full;
    assign ch.empty     = empty;
    assign ch.count     = count_q;
    assign ch.overflow  = overflow_q;
    assign ch.underflow = underflow_q;
endmodule

// File: tb/tb_kpn_fifo_channel.sv
// tb_kpn_fifo_channel: directed stimulus with a token scoreboard checked by a monitor.
`timescale 1ns/1ps
module tb_kpn_fifo_channel;
    localparam logic [15:0] INIT_V = 16'h0010;
`ifdef KPN_CHANNEL_INIT_TOKEN_EN
    localparam int RST_CNT = 1;
`else
    localparam int RST_CNT = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] mq[$];
    logic [15:0] exp_q[$];

    kpn_fifo_channel_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) ch ();

    kpn_fifo_channel #(.DATA_WIDTH(16), .DEPTH(8), .ADDR_WIDTH(3), .INIT_VALUE(INIT_V)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ch    (ch.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && ch.out_valid) begin
            if (exp_q.size() == 0) chk("spurious_out_valid", 1, 0);
            else chk("token", ch.output_1, exp_q.pop_front());
        end
    end

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        if (RST_CNT == 1) mq.push_back(INIT_V);
    endtask

    task automatic step(input logic w, input logic [15:0] d, input logic r);
        bit r_ok, w_ok, e_ov, e_uf;
        ch.wr = w;
        ch.entry_1 = d;
        ch.rd = r;
        r_ok = r && mq.size() > 0;
        w_ok = w && mq.size() < 8;
        e_ov = w && mq.size() == 8;
        e_uf = r && mq.size() == 0;
        if (r_ok) exp_q.push_back(mq.pop_front());
        if (w_ok) mq.push_back(d);
        @(posedge clk);
        #1;
        chk("count", ch.count, mq.size());
        chk("full", ch.full, mq.size() == 8);
        chk("empty", ch.empty, mq.size() == 0);
        chk("overflow", ch.overflow, e_ov);
        chk("underflow", ch.underflow, e_uf);
        chk("out_valid", ch.out_valid, r_ok);
        ch.wr = 1'b0;
        ch.rd = 1'b0;
    endtask

    initial begin
        ch.wr = 1'b0;
        ch.rd = 1'b0;
        ch.entry_1 = '0;
        // Reset held for 3 cycles with wr/rd toggling
        for (int i = 0; i < 3; i++) begin
            ch.wr = (i % 2) == 0;
            ch.rd = (i % 2) == 1;
            ch.entry_1 = 16'h00F0 + 16'(i);
            @(negedge clk);
            chk("rst_count", ch.count, RST_CNT);
            chk("rst_empty", ch.empty, RST_CNT == 0);
            chk("rst_full", ch.full, 0);
            chk("rst_output_1", ch.output_1, 0);
            chk("rst_out_valid", ch.out_valid, 0);
            chk("rst_flags", {ch.overflow, ch.underflow}, 0);
        end
        ch.wr = 1'b0;
        ch.rd = 1'b0;
        rst_n = 1'b1;
        model_reset();
        while (mq.size() > 0) step(0, 0, 1);
        step(0, 0, 0);
        // Three writes then three reads
        step(1, 16'h0003, 0);
        step(1, 16'h0005, 0);
        step(1, 16'h0007, 0);
        chk("t2_count", ch.count, 3);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        chk("t2_output_1", ch.output_1, 16'h0007);
        step(0, 0, 0);
        chk("t2_empty", ch.empty, 1);
        // Nine writes into eight slots
        for (int i = 1; i <= 8; i++) step(1, 16'(i), 0);
        chk("t3_full", ch.full, 1);
        chk("t3_count", ch.count, 8);
        step(1, 16'd9, 0);
        chk("t3_overflow", ch.overflow, 1);
        step(0, 0, 0);
        chk("t3_overflow_once", ch.overflow, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1);
        chk("t3_last", ch.output_1, 16'd8);
        step(0, 0, 0);
        // Full with simultaneous rd and wr
        for (int i = 0; i < 8; i++) step(1, 16'h0020 + 16'(i), 0);
        step(1, 16'h00AA, 1);
        chk("t4_count", ch.count, 7);
        chk("t4_overflow", ch.overflow, 1);
        chk("t4_pop", ch.output_1, 16'h0020);
        step(1, 16'h00AA, 0);
        chk("t4_count_retry", ch.count, 8);
        while (mq.size() > 0) step(0, 0, 1);
        chk("t4_tail", ch.output_1, 16'h00AA);
        step(0, 0, 0);
        // Empty with simultaneous rd and wr
        step(1, 16'h1234, 1);
        chk("t5_underflow", ch.underflow, 1);
        chk("t5_count", ch.count, 1);
        chk("t5_no_valid", ch.out_valid, 0);
        step(0, 0, 1);
        chk("t5_token", ch.output_1, 16'h1234);
        step(0, 0, 0);
        // Streaming across pointer wrap, then reset mid-stream
        step(1, 16'd100, 0);
        for (int i = 1; i < 20; i++) step(1, 16'd100 + 16'(i), 1);
        for (int i = 0; i < 3; i++) step(1, 16'd200 + 16'(i), 0);
        chk("t6_count", ch.count, 4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_count", ch.count, RST_CNT);
        chk("t6_async_valid", ch.out_valid, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 1);
        chk("t6_first_read", ch.output_1, RST_CNT == 1 ? INIT_V : 16'h0000);
        step(0, 0, 0);
        chk("lost_tokens", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
